// File: rtl/jpc_fetch.sv
// jpc_fetch: instruction fetch unit sitting on the consumer side of jpc_pc.
// It reads the current PC, fetches one word over a req/ack memory handshake,
// strobes the next PC back into jpc_pc, and holds the fetched instruction in a
// one-entry valid/ready buffer for decode. Branch redirects flush the buffer;
// a fetch already in flight when a branch arrives is drained and discarded.
module jpc_fetch #(
  parameter int JPC_ADDRESS_WIDTH = 32,
  parameter int JPC_DATA_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [JPC_ADDRESS_WIDTH-1:0] pc_I,
  output logic [JPC_ADDRESS_WIDTH-1:0] next_pc_O,
  output logic                         pc_enable_O,
  output logic                         imem_req_O,
  output logic [JPC_ADDRESS_WIDTH-1:0] imem_addr_O,
  input  logic                         imem_ack_I,
  input  logic [JPC_DATA_WIDTH-1:0]    imem_rdata_I,
  input  logic                         branch_valid_I,
  input  logic [JPC_ADDRESS_WIDTH-1:0] branch_target_I,
  output logic                         inst_valid_O,
  output logic [JPC_DATA_WIDTH-1:0]    inst_O,
  output logic [JPC_ADDRESS_WIDTH-1:0] inst_pc_O,
  input  logic                         inst_ready_I
);

  localparam int AW = JPC_ADDRESS_WIDTH;
  localparam int DW = JPC_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ADV   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            pc_en_q, pc_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   next_pc_q, next_pc_d;
  logic            inst_vld_q, inst_vld_d;
  logic [DW-1:0]   inst_q, inst_d;
  logic [AW-1:0]   inst_pc_q, inst_pc_d;
  logic [AW-1:0]   tgt_q, tgt_d;

  logic            buf_free;
  logic [AW-1:0]   branch_tgt;
  logic [AW-1:0]   pc_aligned;
  logic [AW-1:0]   addr_plus4;

  // Byte-offset bits of the incoming addresses are deliberately dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_I[1:0], branch_target_I[1:0]};

  assign branch_tgt = {branch_target_I[AW-1:2], 2'b00};
  assign pc_aligned = {pc_I[AW-1:2], 2'b00};
  // Wraps modulo 2^AW, so the top word rolls over to address 0.
  assign addr_plus4 = addr_q + {{(AW-3){1'b0}}, 3'b100};
  // The buffer can accept a new fetch if empty or being dequeued this cycle.
  assign buf_free   = !inst_vld_q || inst_ready_I;

  // Next-state logic for the fetch FSM, instruction buffer and redirect target.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    next_pc_d  = next_pc_q;
    inst_vld_d = inst_vld_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    tgt_d      = tgt_q;

    if (inst_vld_q && inst_ready_I) begin
      inst_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (branch_valid_I) begin
          next_pc_d = branch_tgt;
          state_d   = S_ADV;
        end else if (buf_free) begin
          addr_d  = pc_aligned;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack_I) begin
          if (branch_valid_I) begin
            next_pc_d = branch_tgt;
          end else begin
            inst_d     = imem_rdata_I;
            inst_pc_d  = addr_q;
            inst_vld_d = 1'b1;
            next_pc_d  = addr_plus4;
          end
          state_d = S_ADV;
        end else if (branch_valid_I) begin
          state_d = S_DRAIN;
        end
      end
      S_ADV: begin
        // A branch here re-strobes jpc_pc with the target; the later load wins.
        if (branch_valid_I) begin
          next_pc_d = branch_tgt;
          state_d   = S_ADV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Stale data is thrown away; the most recent branch target is used.
        if (imem_ack_I) begin
          next_pc_d = branch_valid_I ? branch_tgt : tgt_q;
          state_d   = S_ADV;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_valid_I) begin
      tgt_d      = branch_tgt;
      inst_vld_d = 1'b0;
    end

    req_d   = (state_d == S_REQ) || (state_d == S_DRAIN);
    pc_en_d = (state_d == S_ADV);
  end

  // All state and registered Moore outputs; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      pc_en_q    <= 1'b0;
      addr_q     <= '0;
      next_pc_q  <= '0;
      inst_vld_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pc_en_q    <= pc_en_d;
      addr_q     <= addr_d;
      next_pc_q  <= next_pc_d;
      inst_vld_q <= inst_vld_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      tgt_q      <= tgt_d;
    end
  end

  assign imem_req_O   = req_q;
  assign imem_addr_O  = addr_q;
  assign pc_enable_O  = pc_en_q;
  assign next_pc_O    = next_pc_q;
  assign inst_valid_O = inst_vld_q;
  assign inst_O       = inst_q;
  assign inst_pc_O    = inst_pc_q;

endmodule

// File: tb/tb_jpc_fetch.sv
// Testbench for jpc_fetch: a small jpc_pc register model and a wait-state
// memory model surround the DUT. Directed stimulus pushes expected PC strobes
// and fetched instructions into queues that a negedge monitor pops.
module tb_jpc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_I;
  logic [31:0] next_pc_O;
  logic        pc_enable_O;
  logic        imem_req_O;
  logic [31:0] imem_addr_O;
  logic        imem_ack_I;
  logic [31:0] imem_rdata_I;
  logic        branch_valid_I;
  logic [31:0] branch_target_I;
  logic        inst_valid_O;
  logic [31:0] inst_O;
  logic [31:0] inst_pc_O;
  logic        inst_ready_I;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc_q[$];
  logic [63:0] exp_inst_q[$];

  logic [31:0] pc_model;
  logic        pc_ovr_en;
  logic [31:0] pc_ovr;
  int          wait_cfg;
  int          wcnt;
  logic        prev_v;

  jpc_fetch #(.JPC_ADDRESS_WIDTH(32), .JPC_DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_I            (pc_I),
    .next_pc_O       (next_pc_O),
    .pc_enable_O     (pc_enable_O),
    .imem_req_O      (imem_req_O),
    .imem_addr_O     (imem_addr_O),
    .imem_ack_I      (imem_ack_I),
    .imem_rdata_I    (imem_rdata_I),
    .branch_valid_I  (branch_valid_I),
    .branch_target_I (branch_target_I),
    .inst_valid_O    (inst_valid_O),
    .inst_O          (inst_O),
    .inst_pc_O       (inst_pc_O),
    .inst_ready_I    (inst_ready_I)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return a ^ 32'hC0DE_0000;
  endfunction

  // jpc_pc model: loads next_pc_O on the pc_enable_O strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_model <= 32'h0;
    else if (pc_enable_O) pc_model <= next_pc_O;
  end
  assign pc_I = pc_ovr_en ? pc_ovr : pc_model;

  // Memory model: ack after wait_cfg cycles of a held request.
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req_O && !imem_ack_I) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_ack_I   = imem_req_O && (wcnt >= wait_cfg);
  assign imem_rdata_I = mem_word(imem_addr_O);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " next_pc"}, next_pc_O, 32'h0);
    check({tag, " pc_enable"}, {31'h0, pc_enable_O}, 32'h0);
    check({tag, " imem_req"}, {31'h0, imem_req_O}, 32'h0);
    check({tag, " imem_addr"}, imem_addr_O, 32'h0);
    check({tag, " inst_valid"}, {31'h0, inst_valid_O}, 32'h0);
    check({tag, " inst"}, inst_O, 32'h0);
    check({tag, " inst_pc"}, inst_pc_O, 32'h0);
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] npc);
    exp_inst_q.push_back({a, mem_word(a)});
    exp_pc_q.push_back(npc);
  endtask

  // Monitor: pops expectations whenever the DUT strobes a PC or presents a new instruction.
  always @(negedge clk) begin
    if (rst) begin
      if (pc_enable_O) begin
        if (exp_pc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected pc_enable: got next_pc %h expected no strobe", next_pc_O);
        end else begin
          check("sb next_pc", next_pc_O, exp_pc_q.pop_front());
        end
      end
      if (inst_valid_O && !prev_v) begin
        if (exp_inst_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected inst: got %h at %h expected none", inst_O, inst_pc_O);
        end else begin
          logic [63:0] e;
          e = exp_inst_q.pop_front();
          check("sb inst", inst_O, e[31:0]);
          check("sb inst_pc", inst_pc_O, e[63:32]);
        end
      end
    end
    prev_v <= inst_valid_O;
  end

  initial begin
    rst = 1'b0;
    branch_valid_I = 1'b0;
    branch_target_I = 32'h0;
    inst_ready_I = 1'b1;
    pc_ovr_en = 1'b0;
    pc_ovr = 32'h0;
    wait_cfg = 0;
    prev_v = 1'b0;

    // Reset state and first zero-wait fetch
    tick();
    tick();
    check_all_zero("reset");
    push_fetch(32'h0, 32'h4);
    rst = 1'b1;
    tick();
    check("t1 req", {31'h0, imem_req_O}, 32'h1);
    check("t1 addr", imem_addr_O, 32'h0);
    check("t1 pc_en early", {31'h0, pc_enable_O}, 32'h0);
    tick();
    check("t1 valid", {31'h0, inst_valid_O}, 32'h1);
    check("t1 inst", inst_O, 32'h13);
    check("t1 pc_en", {31'h0, pc_enable_O}, 32'h1);
    check("t1 next_pc", next_pc_O, 32'h4);
    check("t1 req drop", {31'h0, imem_req_O}, 32'h0);
    inst_ready_I = 1'b0;
    wait_cfg = 3;

    // Backpressure: instruction stays buffered, no new request
    tick();
    check("t3 pc_en gone", {31'h0, pc_enable_O}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3 stall req", {31'h0, imem_req_O}, 32'h0);
      check("t3 stall valid", {31'h0, inst_valid_O}, 32'h1);
    end
    push_fetch(32'h4, 32'h8);
    inst_ready_I = 1'b1;
    tick();
    check("t3 dequeue", {31'h0, inst_valid_O}, 32'h0);
    check("t3 req", {31'h0, imem_req_O}, 32'h1);
    check("t3 addr", imem_addr_O, 32'h4);

    // Wait states: req/addr stable for 4 cycles, ack in the 4th
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("t2 req hold", {31'h0, imem_req_O}, 32'h1);
      check("t2 addr hold", imem_addr_O, 32'h4);
      check("t2 no pc_en", {31'h0, pc_enable_O}, 32'h0);
    end
    inst_ready_I = 1'b0;
    tick();
    check("t2 valid", {31'h0, inst_valid_O}, 32'h1);
    check("t2 inst", inst_O, mem_word(32'h4));
    check("t2 pc_en", {31'h0, pc_enable_O}, 32'h1);
    check("t2 next_pc", next_pc_O, 32'h8);
    tick();

    // Branch during pending request at 0x8
    inst_ready_I = 1'b1;
    tick();
    check("t4 req", {31'h0, imem_req_O}, 32'h1);
    check("t4 addr", imem_addr_O, 32'h8);
    inst_ready_I = 1'b0;
    branch_valid_I = 1'b1;
    branch_target_I = 32'h100;
    exp_pc_q.push_back(32'h100);
    tick();
    branch_valid_I = 1'b0;
    check("t4 drain req", {31'h0, imem_req_O}, 32'h1);
    check("t4 drain addr", imem_addr_O, 32'h8);
    check("t4 drain valid", {31'h0, inst_valid_O}, 32'h0);
    check("t4 drain pc_en", {31'h0, pc_enable_O}, 32'h0);
    tick();
    check("t4 drain req2", {31'h0, imem_req_O}, 32'h1);
    tick();
    check("t4 drain req3", {31'h0, imem_req_O}, 32'h1);
    tick();
    check("t4 redirect pc_en", {31'h0, pc_enable_O}, 32'h1);
    check("t4 redirect next_pc", next_pc_O, 32'h100);
    check("t4 data dropped", {31'h0, inst_valid_O}, 32'h0);
    wait_cfg = 0;
    push_fetch(32'h100, 32'h104);
    tick();
    tick();
    check("t4 target req addr", imem_addr_O, 32'h100);
    tick();
    check("t4 target inst_pc", inst_pc_O, 32'h100);
    check("t4 target next_pc", next_pc_O, 32'h104);

    // Branch with valid buffer, coincident with ack, and in the ADV cycle
    tick();
    check("t5 buffered", {31'h0, inst_valid_O}, 32'h1);
    branch_valid_I = 1'b1;
    branch_target_I = 32'h200;
    exp_pc_q.push_back(32'h200);
    tick();
    branch_valid_I = 1'b0;
    check("t5 flushed", {31'h0, inst_valid_O}, 32'h0);
    check("t5 flush next_pc", next_pc_O, 32'h200);
    tick();
    tick();
    check("t5 req addr", imem_addr_O, 32'h200);
    check("t5 ack now", {31'h0, imem_ack_I}, 32'h1);
    branch_valid_I = 1'b1;
    branch_target_I = 32'h300;
    exp_pc_q.push_back(32'h300);
    tick();
    check("t5 ack+branch dropped", {31'h0, inst_valid_O}, 32'h0);
    check("t5 ack+branch next_pc", next_pc_O, 32'h300);
    branch_target_I = 32'h407;
    exp_pc_q.push_back(32'h404);
    tick();
    branch_valid_I = 1'b0;
    check("t5 adv branch pc_en", {31'h0, pc_enable_O}, 32'h1);
    check("t5 adv branch next_pc", next_pc_O, 32'h404);
    push_fetch(32'h404, 32'h408);
    tick();
    tick();
    check("t5 last strobe addr", imem_addr_O, 32'h404);
    tick();
    check("t5 capture valid", {31'h0, inst_valid_O}, 32'h1);

    // Address wrap and ignored low PC bits
    inst_ready_I = 1'b1;
    pc_ovr_en = 1'b1;
    pc_ovr = 32'hFFFF_FFFF;
    push_fetch(32'hFFFF_FFFC, 32'h0);
    tick();
    check("t6 dequeued", {31'h0, inst_valid_O}, 32'h0);
    tick();
    check("t6 req addr", imem_addr_O, 32'hFFFF_FFFC);
    tick();
    check("t6 wrap pc_en", {31'h0, pc_enable_O}, 32'h1);
    check("t6 wrap next_pc", next_pc_O, 32'h0);

    // Reset while a request is outstanding
    pc_ovr = 32'h40;
    wait_cfg = 5;
    tick();
    tick();
    check("t6 rst req", {31'h0, imem_req_O}, 32'h1);
    check("t6 rst addr", imem_addr_O, 32'h40);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async reset");
    tick();
    check("exp_pc queue drained", exp_pc_q.size(), 32'h0);
    check("exp_inst queue drained", exp_inst_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
